// File: rtl/if_stage.sv
// Instruction-fetch stage: sync-SRAM fetch, one-entry stall buffer, edge-detected branch redirect.
// Define IF_ADEF_CHK_EN to flag misaligned fetch addresses and substitute a trap instruction.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        if_to_id_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_excp_adef,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic [31:0] RESET_PC  = 32'h1bff_fffc;
  localparam logic [31:0] ADEF_INST = 32'h0340_0000;

  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_pend_target_q, br_pend_target_d;
  logic        inst_buf_valid_q, inst_buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_taken_q, br_taken_d;
  logic        adef_q, adef_d;

  logic        br_new;
  logic        if_allowin;
  logic        fetch;
  logic        cancel;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;

  // A held br_taken redirects only once, on its rising edge.
  assign br_new     = br_taken & ~br_taken_q;
  assign if_allowin = ~if_valid_q | id_allowin;
  assign fetch      = ~reset & if_allowin;
  assign cancel     = ~if_allowin & br_new;
  assign seq_pc     = if_pc_q + 32'd4;
  assign nextpc     = br_new ? br_target : (br_pend_q ? br_pend_target_q : seq_pc);

  always_comb begin
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    br_pend_d        = br_pend_q;
    br_pend_target_d = br_pend_target_q;
    inst_buf_valid_d = inst_buf_valid_q;
    inst_buf_d       = inst_buf_q;
    br_taken_d       = br_taken;
    adef_d           = adef_q;

    if (fetch) begin
      if_valid_d = 1'b1;
      if_pc_d    = nextpc;
      br_pend_d  = 1'b0;
`ifdef IF_ADEF_CHK_EN
      adef_d     = (nextpc[1:0] != 2'b00);
`endif
    end else if (cancel) begin
      if_valid_d       = 1'b0;
      br_pend_d        = 1'b1;
      br_pend_target_d = br_target;
    end

    // SRAM rdata is only valid the cycle after a fetch, so capture it on the first stall cycle.
    if (cancel) begin
      inst_buf_valid_d = 1'b0;
      inst_buf_d       = 32'd0;
    end else if (if_valid_q & id_allowin) begin
      inst_buf_valid_d = 1'b0;
    end else if (if_valid_q & ~id_allowin & ~inst_buf_valid_q) begin
      inst_buf_valid_d = 1'b1;
      inst_buf_d       = inst_sram_rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q       <= 1'b0;
      if_pc_q          <= RESET_PC;
      br_pend_q        <= 1'b0;
      br_pend_target_q <= 32'd0;
      inst_buf_valid_q <= 1'b0;
      inst_buf_q       <= 32'd0;
      br_taken_q       <= 1'b0;
      adef_q           <= 1'b0;
    end else begin
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      br_pend_q        <= br_pend_d;
      br_pend_target_q <= br_pend_target_d;
      inst_buf_valid_q <= inst_buf_valid_d;
      inst_buf_q       <= inst_buf_d;
      br_taken_q       <= br_taken_d;
      adef_q           <= adef_d;
    end
  end

  assign if_to_id_valid  = if_valid_q;
  assign if_pc           = if_pc_q;
  assign if_excp_adef    = adef_q;
  assign if_inst         = adef_q ? ADEF_INST : (inst_buf_valid_q ? inst_buf_q : inst_sram_rdata);
  assign inst_sram_en    = fetch;
  assign inst_sram_we    = 4'd0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural 1-cycle-latency instruction SRAM.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        if_to_id_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_excp_adef;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .id_allowin     (id_allowin),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_to_id_valid (if_to_id_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_excp_adef   (if_excp_adef),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_we   (inst_sram_we),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5a5a_0000;
  endfunction

  // Reads return garbage when the SRAM was not enabled.
  always @(posedge clk)
    inst_sram_rdata <= inst_sram_en ? inst_of(inst_sram_addr) : $urandom;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1; id_allowin = 1'b1; br_taken = 1'b0; br_target = 32'd0;
    repeat (3) step();
    check("rst_valid", {31'd0, if_to_id_valid}, 32'd0);
    check("rst_pc", if_pc, 32'h1bff_fffc);
    check("rst_en", {31'd0, inst_sram_en}, 32'd0);
    check("rst_adef", {31'd0, if_excp_adef}, 32'd0);
    check("we_zero", {28'd0, inst_sram_we}, 32'd0);
    check("wdata_zero", inst_sram_wdata, 32'd0);

    // Sequential fetch after reset release
    reset = 1'b0; settle();
    check("first_en", {31'd0, inst_sram_en}, 32'd1);
    check("first_addr", inst_sram_addr, 32'h1c00_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("seq_pc", if_pc, 32'h1c00_0000 + 32'(4 * i));
      check("seq_valid", {31'd0, if_to_id_valid}, 32'd1);
      check("seq_inst", if_inst, inst_of(32'h1c00_0000 + 32'(4 * i)));
      check("seq_addr", inst_sram_addr, 32'h1c00_0004 + 32'(4 * i));
    end

    // Stall holding pc 0x1c000010 for five cycles
    id_allowin = 1'b0; settle();
    check("stall_en", {31'd0, inst_sram_en}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_pc", if_pc, 32'h1c00_0010);
      check("stall_inst", if_inst, inst_of(32'h1c00_0010));
    end
    id_allowin = 1'b1; settle();
    check("resume_addr", inst_sram_addr, 32'h1c00_0014);
    step();
    check("resume_pc", if_pc, 32'h1c00_0014);
    check("resume_inst", if_inst, inst_of(32'h1c00_0014));

    // Branch with ID accepting, br_taken held three cycles
    br_taken = 1'b1; br_target = 32'h1c00_0100; settle();
    check("br_addr", inst_sram_addr, 32'h1c00_0100);
    step();
    check("br_pc", if_pc, 32'h1c00_0100);
    check("br_hold_addr", inst_sram_addr, 32'h1c00_0104);
    step();
    check("br_hold_pc1", if_pc, 32'h1c00_0104);
    step();
    check("br_hold_pc2", if_pc, 32'h1c00_0108);
    br_taken = 1'b0; settle();
    check("br_after_addr", inst_sram_addr, 32'h1c00_010c);
    step();
    check("br_after_inst", if_inst, inst_of(32'h1c00_010c));

    // Branch while ID stalled: cancel, pending redirect
    id_allowin = 1'b0; br_taken = 1'b1; br_target = 32'h1c00_0200; settle();
    step();
    check("cancel_valid", {31'd0, if_to_id_valid}, 32'd0);
    check("pend_en", {31'd0, inst_sram_en}, 32'd1);
    check("pend_addr", inst_sram_addr, 32'h1c00_0200);
    step();
    check("pend_pc", if_pc, 32'h1c00_0200);
    check("pend_valid", {31'd0, if_to_id_valid}, 32'd1);
    step();
    check("held_no_cancel", {31'd0, if_to_id_valid}, 32'd1);
    check("held_pc", if_pc, 32'h1c00_0200);
    check("held_inst", if_inst, inst_of(32'h1c00_0200));
    id_allowin = 1'b1; br_taken = 1'b0; settle();
    check("pend_cleared_addr", inst_sram_addr, 32'h1c00_0204);
    step();
    check("pend_cleared_pc", if_pc, 32'h1c00_0204);

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h1c00_0102; settle();
    step();
    br_taken = 1'b0;
    check("mis_pc", if_pc, 32'h1c00_0102);
`ifdef IF_ADEF_CHK_EN
    check("mis_adef", {31'd0, if_excp_adef}, 32'd1);
    check("mis_inst", if_inst, 32'h0340_0000);
`else
    check("mis_adef", {31'd0, if_excp_adef}, 32'd0);
    check("mis_inst", if_inst, inst_of(32'h1c00_0102));
`endif
    step();
    check("mis_next_pc", if_pc, 32'h1c00_0106);
    check("mis_next_adef", {31'd0, if_excp_adef}, 32'd0);

    // Reset with a buffered instruction discards it
    id_allowin = 1'b0; step(); step();
    reset = 1'b1; step();
    check("rst2_valid", {31'd0, if_to_id_valid}, 32'd0);
    check("rst2_pc", if_pc, 32'h1bff_fffc);
    reset = 1'b0; settle();
    check("rst2_addr", inst_sram_addr, 32'h1c00_0000);
    step();
    check("rst2_inst", if_inst, inst_of(32'h1c00_0000));

    // Reset with a pending branch discards it
    step();
    br_taken = 1'b1; br_target = 32'h1c00_0300; step();
    check("pend2_set_valid", {31'd0, if_to_id_valid}, 32'd0);
    br_taken = 1'b0; reset = 1'b1; step();
    reset = 1'b0; id_allowin = 1'b1; settle();
    check("rst3_addr", inst_sram_addr, 32'h1c00_0000);
    step();
    check("rst3_pc", if_pc, 32'h1c00_0000);
    check("rst3_next_addr", inst_sram_addr, 32'h1c00_0004);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
